// File: rtl/run_length_detector_pkg.sv
//------------------------------------------------------------------------------
// Module : run_len_pkg
// Brief  : FSM state encoding and saturation helper for run_length_detector.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package run_len_pkg;

  // 2'd3 is unused; the detector treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int unsigned SAT_MAX(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/run_length_detector_if.sv
//------------------------------------------------------------------------------
// Module : run_length_detector_if
// Brief  : Sample input and run-report output bundle of run_length_detector.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface run_length_detector_if #(
  parameter int CNT_W  = 4,
  parameter int RCNT_W = 8
);
  logic              en;
  logic              x;
  logic              mode;
  logic [CNT_W-1:0]  len_o;
  logic              valid_o;
  logic              sat_o;
  logic              busy_o;
  logic [RCNT_W-1:0] runs_o;

  modport master (
    output en, x, mode,
    input  len_o, valid_o, sat_o, busy_o, runs_o
  );

  modport slave (
    input  en, x, mode,
    output len_o, valid_o, sat_o, busy_o, runs_o
  );
endinterface

`default_nettype wire

// File: rtl/run_length_detector_sat_counter.sv
//------------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Up-counter that sticks at 2^CNT_W-1; clear has priority over inc.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter
  import run_len_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              i_clr,
  input  wire              i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_max
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(SAT_MAX(CNT_W));

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == c_max);

endmodule

`default_nettype wire

// File: rtl/run_length_detector.sv
//------------------------------------------------------------------------------
// Module : run_length_detector
// Brief  : Measures delimiter-framed runs of mark symbols on a serial input.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module run_length_detector
  import run_len_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int MIN_RUN = 1,
  parameter int RCNT_W  = 8
) (
  input  wire                  clk,
  input  wire                  rst,
  run_length_detector_if.slave bus
);

  localparam logic [CNT_W-1:0] c_min_run = CNT_W'(MIN_RUN);

  state_t            r_state;
  logic              r_mode_q;
  logic [CNT_W-1:0]  r_len;
  logic              r_valid;
  logic              r_sat;
  logic [RCNT_W-1:0] r_runs;

  logic [CNT_W-1:0]  w_cnt;
  logic              w_at_max;
  logic              w_delim;
  logic              w_mode_chg;
  logic              w_counting;
  logic              w_clr;
  logic              w_inc;

  assign w_delim    = (bus.x == bus.mode);
  assign w_mode_chg = (bus.mode != r_mode_q);
  assign w_counting = (r_state == ARMED) || (r_state == RUN);

  // The counter is zero on entry to ARMED, so a single inc yields the first mark.
  assign w_clr = bus.en && (w_mode_chg || !w_counting || ((r_state == RUN) && w_delim));
  assign w_inc = bus.en && !w_mode_chg && !w_delim && w_counting;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_inc    (w_inc),
    .o_cnt    (w_cnt),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mode_q <= 1'b0;
      r_len    <= '0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
      r_runs   <= '0;
    end else begin
      r_valid <= 1'b0;
      if (bus.en) begin
        r_mode_q <= bus.mode;
        if (w_mode_chg) begin
          r_state <= IDLE;
        end else begin
          case (r_state)
            IDLE:  if (w_delim)  r_state <= ARMED;
            ARMED: if (!w_delim) r_state <= RUN;
            RUN: begin
              if (w_delim) begin
                r_state <= ARMED;
                if (w_cnt >= c_min_run) begin
                  r_len   <= w_cnt;
                  r_sat   <= w_at_max;
                  r_valid <= 1'b1;
                  r_runs  <= r_runs + 1'b1;
                end
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.len_o   = r_len;
  assign bus.valid_o = r_valid;
  assign bus.sat_o   = r_sat;
  assign bus.busy_o  = (r_state == RUN);
  assign bus.runs_o  = r_runs;

endmodule

`default_nettype wire

// File: tb/tb_run_length_detector.sv
//------------------------------------------------------------------------------
// Module : tb_run_length_detector
// Brief  : Directed vectors against two detectors (MIN_RUN=1 and MIN_RUN=3).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_run_length_detector;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  run_length_detector_if #(.CNT_W(4), .RCNT_W(8)) bus_a ();
  run_length_detector_if #(.CNT_W(4), .RCNT_W(8)) bus_b ();

  run_length_detector #(.CNT_W(4), .MIN_RUN(1), .RCNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  run_length_detector #(.CNT_W(4), .MIN_RUN(3), .RCNT_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rst;
    int en;
    int mode;
    int x;
    int valid;
    int len;
    int sat;
    int busy;
    int runs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive both detectors identically, then sample 1 time unit after the edge.
  task automatic step(input int r, input int e, input int m, input int xv);
    rst        = r[0];
    bus_a.en   = e[0];
    bus_a.mode = m[0];
    bus_a.x    = xv[0];
    bus_b.en   = e[0];
    bus_b.mode = m[0];
    bus_b.x    = xv[0];
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int v, input int l, input int s,
                       input int b, input int r);
    chk({tag, ".a.valid"}, int'(bus_a.valid_o), v);
    chk({tag, ".a.len"},   int'(bus_a.len_o),   l);
    chk({tag, ".a.sat"},   int'(bus_a.sat_o),   s);
    chk({tag, ".a.busy"},  int'(bus_a.busy_o),  b);
    chk({tag, ".a.runs"},  int'(bus_a.runs_o),  r);
  endtask

  task automatic chk_b(input string tag, input int v, input int l, input int s,
                       input int b, input int r);
    chk({tag, ".b.valid"}, int'(bus_b.valid_o), v);
    chk({tag, ".b.len"},   int'(bus_b.len_o),   l);
    chk({tag, ".b.sat"},   int'(bus_b.sat_o),   s);
    chk({tag, ".b.busy"},  int'(bus_b.busy_o),  b);
    chk({tag, ".b.runs"},  int'(bus_b.runs_o),  r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_err = 0;
    n_chk = 0;
    rst   = 1'b1;

    //              rst en md x  val len sat busy runs
    tbl.push_back('{1, 1, 0, 0,  0,  0,  0,  0,   0});  // reset state
    tbl.push_back('{0, 1, 0, 0,  0,  0,  0,  0,   0});  // delimiter arms
    tbl.push_back('{0, 1, 0, 1,  0,  0,  0,  1,   0});
    tbl.push_back('{0, 1, 0, 1,  0,  0,  0,  1,   0});
    tbl.push_back('{0, 1, 0, 0,  1,  2,  0,  0,   1});  // run of 2
    tbl.push_back('{0, 0, 0, 1,  0,  2,  0,  0,   1});  // en=0 holds
    tbl.push_back('{1, 1, 0, 1,  0,  0,  0,  0,   0});  // reset again
    tbl.push_back('{0, 1, 0, 1,  0,  0,  0,  0,   0});  // leading run ignored
    tbl.push_back('{0, 1, 0, 1,  0,  0,  0,  0,   0});
    tbl.push_back('{0, 1, 0, 0,  0,  0,  0,  0,   0});
    tbl.push_back('{0, 1, 0, 1,  0,  0,  0,  1,   0});
    tbl.push_back('{0, 1, 0, 0,  1,  1,  0,  0,   1});
    tbl.push_back('{0, 1, 0, 0,  0,  1,  0,  0,   1});  // repeated delimiter
    tbl.push_back('{0, 1, 0, 1,  0,  1,  0,  1,   1});  // back-to-back runs
    tbl.push_back('{0, 1, 0, 0,  1,  1,  0,  0,   2});
    tbl.push_back('{0, 1, 0, 1,  0,  1,  0,  1,   2});
    tbl.push_back('{0, 1, 0, 0,  1,  1,  0,  0,   3});
    tbl.push_back('{0, 1, 0, 1,  0,  1,  0,  1,   3});
    tbl.push_back('{0, 1, 1, 0,  0,  1,  0,  0,   3});  // mode flip aborts run
    tbl.push_back('{0, 1, 1, 1,  0,  1,  0,  0,   3});  // mode=1 delimiter
    tbl.push_back('{0, 1, 1, 0,  0,  1,  0,  1,   3});
    tbl.push_back('{0, 1, 1, 0,  0,  1,  0,  1,   3});
    tbl.push_back('{0, 0, 1, 1,  0,  1,  0,  1,   3});  // enable gap
    tbl.push_back('{0, 0, 1, 1,  0,  1,  0,  1,   3});
    tbl.push_back('{0, 1, 1, 0,  0,  1,  0,  1,   3});
    tbl.push_back('{0, 1, 1, 1,  1,  3,  0,  0,   4});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].x);
      chk_a($sformatf("vec%0d", i), tbl[i].valid, tbl[i].len, tbl[i].sat,
            tbl[i].busy, tbl[i].runs);
    end

    // Saturation: twenty marks clamp at 15 while staying in RUN.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 1);
      chk($sformatf("sat.busy%0d", i), int'(bus_a.busy_o), 1);
      chk($sformatf("sat.valid%0d", i), int'(bus_a.valid_o), 0);
    end
    chk("sat.cnt", int'(dut_a.u_cnt.o_cnt), 15);
    step(0, 1, 0, 0);
    chk_a("sat", 1, 15, 1, 0, 1);
    chk_b("sat", 1, 15, 1, 0, 1);

    // Minimum-length filter: a run of 2 is dropped by the MIN_RUN=3 detector.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    chk_a("min2", 1, 2, 0, 0, 1);
    chk_b("min2", 0, 0, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    chk_a("min3", 1, 3, 0, 0, 2);
    chk_b("min3", 1, 3, 0, 0, 1);

    // Reset mid-run discards the run and needs a fresh delimiter.
    step(0, 1, 0, 1);
    chk("mid.busy_a", int'(bus_a.busy_o), 1);
    chk("mid.busy_b", int'(bus_b.busy_o), 1);
    step(1, 1, 0, 1);
    chk_a("mid.rst", 0, 0, 0, 0, 0);
    chk_b("mid.rst", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk_a("mid.delim", 0, 0, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    chk_a("mid.next", 1, 1, 0, 0, 1);
    chk_b("mid.next", 0, 0, 0, 0, 0);

    // 255 further runs take runs_o from 1 around to 0.
    for (int i = 0; i < 255; i++) begin
      step(0, 1, 0, 1);
      step(0, 1, 0, 0);
    end
    chk_a("wrap", 1, 1, 0, 0, 0);
    chk("wrap.b.runs", int'(bus_b.runs_o), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Parametrised successor to the team's fixed 3-bit Mealy run detector.
- Measures the length of each run of "mark" symbols on a serial input. A run is only measured if a delimiter symbol precedes it; it is reported when the next delimiter arrives.
- Adds a programmable counter width, a minimum-length filter, a selectable mark polarity, saturation reporting, registered outputs and a sample enable.
- Sits behind the serial line-sampling stage and feeds the statistics/decoder logic.

Parameters:
- CNT_W, 4: run-length counter width. MAX = 2^CNT_W-1 is the saturation value.
- MIN_RUN, 1: shortest run that is reported. Legal range is 1..MAX; shorter runs are discarded silently.
- RCNT_W, 8: width of the reported-run tally.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high, clock clk
- en  input  1  sample enable; x is consumed only on cycles where en=1
- x  input  1  serial data sample
- mode  input  1  0 = mark is 1, delimiter is 0; 1 = mark is 0, delimiter is 1
- len_o  output  CNT_W  length of the last reported run (saturated)
- valid_o  output  1  one-cycle pulse; len_o/sat_o are new this cycle
- sat_o  output  1  the reported run reached MAX (true length >= MAX)
- busy_o  output  1  FSM is in RUN
- runs_o  output  RCNT_W  count of reported runs, wraps modulo 2^RCNT_W

Behaviour:
- Reset:
  - State goes to IDLE; cnt, len_o, sat_o, runs_o and mode_q clear to 0.
  - valid_o and busy_o are 0.
  - rst has priority over en and over every other event.
- Timing: all outputs are registered. An enabled sample at edge N changes state at N; valid_o, len_o and sat_o are visible after edge N. Latency is 1 clock from the terminating delimiter sample.
- en=0: state, cnt, len_o, sat_o and runs_o hold. valid_o is 0.
- Symbol decode: mark = ~mode. An enabled sample is a delimiter when x == mode.
- FSM (evaluated only when en=1):
  - IDLE: delimiter -> ARMED; mark -> stay in IDLE. A run with no leading delimiter is never counted.
  - ARMED: mark -> RUN with cnt=1; delimiter -> stay in ARMED.
  - RUN, mark: cnt = min(cnt+1, MAX); stay in RUN.
  - RUN, delimiter: go to ARMED and clear cnt. If cnt >= MIN_RUN: len_o = cnt, sat_o = (cnt == MAX), valid_o = 1 for one cycle, runs_o = runs_o+1. Otherwise no report, and len_o/sat_o hold.
- Mode change:
  - mode_q registers mode on every enabled cycle.
  - An enabled sample where mode != mode_q forces IDLE and clears cnt, with no report. x is ignored on that sample.
- Saturation: cnt never wraps. A run of any length >= MAX reports len_o=MAX with sat_o=1.
- busy_o = (state == RUN).
- Reset mid-run: the run is discarded, no valid_o is produced, and the FSM needs a fresh delimiter.
- runs_o wraps from 2^RCNT_W-1 to 0 with no flag.
- Back-to-back runs: the pattern delimiter, mark, delimiter, mark, delimiter yields two reports, each 1 cycle after its terminating delimiter. One delimiter both terminates a run and arms the next.

Decomposition:
- Package run_len_pkg holds the state typedef (IDLE=2'd0, ARMED=2'd1, RUN=2'd2; 2'd3 is illegal and recovers to IDLE) and a SAT_MAX(CNT_W) constant function.
- One sub-module, sat_counter (CNT_W), is a saturating up-counter with sync clear, inc and at_max outputs.
- The FSM and output registers stay in run_length_detector.

Test Plan:
- Reset, then en=1, mode=0, x = 0,1,1,0 -> single valid_o one cycle after the second 0, with len_o=2, sat_o=0, runs_o=1.
- Leading run: after reset x = 1,1,0,1,0 -> exactly one valid_o with len_o=1; the leading 1,1 is discarded.
- Saturation, CNT_W=4: x = 0, then twenty 1s, then 0 -> len_o=15, sat_o=1; cnt holds at 15 during the run and busy_o=1 throughout.
- MIN_RUN=3: x = 0,1,1,0,1,1,1,0 -> run of 2 gives no valid_o; run of 3 gives len_o=3, runs_o=1.
- Enable gaps and mode:
  - mode=1, x = 1,0,0,0,1 with en deasserted for 2 cycles mid-run -> len_o=3, and no valid_o during the gap.
  - Toggling mode mid-run -> no report, and the FSM returns to IDLE.
- Reset mid-run (rst asserted for 1 cycle while busy_o=1), followed by a delimiter -> no valid_o; runs_o=0; the next valid run is measured from 1.
